// File: rtl/clkdiv_sched_if.sv
// Configuration handshake bundle for clkdiv_sched.
// Latency: none, wires only.
// Backpressure: cfg_ready low holds the master's request.
interface clkdiv_sched_if;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [1:0]  cfg_ch;
  logic [16:0] cfg_half;
  logic        cfg_en;
  logic        cfg_done;
  logic        cfg_err;

  modport master (
    output cfg_valid, cfg_ch, cfg_half, cfg_en,
    input  cfg_ready, cfg_done, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_half, cfg_en,
    output cfg_ready, cfg_done, cfg_err
  );
endinterface

// File: rtl/clkdiv_sched.sv
// Three-channel clock divider with a one-slot, glitch-free runtime config scheduler.
// Latency: toggle/tick registered one cycle after terminal count; cfg_done/cfg_err one cycle after apply/accept.
// Backpressure: cfg_ready drops while a config is pending; optional sync_req port under CLKDIV_SCHED_SYNC_EN.
module clkdiv_sched #(
  parameter int unsigned HALF0_DEF = 53,
  parameter int unsigned HALF1_DEF = 26,
  parameter int unsigned HALF2_DEF = 1060,
  parameter logic [2:0]  EN_DEF    = 3'b111
) (
  input  logic             clk_in,
  input  logic             rst,
`ifdef CLKDIV_SCHED_SYNC_EN
  input  logic             sync_req,
`endif
  clkdiv_sched_if.slave    cfg,
  output logic [2:0]       clk_out,
  output logic [2:0]       tick
);

  function automatic logic [16:0] half_def(input int idx);
    case (idx)
      0:       return 17'(HALF0_DEF);
      1:       return 17'(HALF1_DEF);
      default: return 17'(HALF2_DEF);
    endcase
  endfunction

  logic [16:0] cnt  [3];
  logic [16:0] half [3];
  logic [2:0]  en;

  logic        pend;
  logic [1:0]  pend_ch;
  logic [16:0] pend_half;
  logic        pend_en;

  logic        done_r;
  logic        err_r;
  logic        sync;
  logic        accept;
  logic        apply;

`ifdef CLKDIV_SCHED_SYNC_EN
  assign sync = sync_req;
`else
  assign sync = 1'b0;
`endif

  assign cfg.cfg_ready = ~pend;
  assign cfg.cfg_done  = done_r;
  assign cfg.cfg_err   = err_r;
  assign accept        = cfg.cfg_valid & ~pend;

  // Decide whether the pending config lands this cycle: immediately on a
  // disabled target, otherwise only on a terminal count (and, when
  // disabling, only on the falling terminal so the output never glitches).
  always_comb begin
    apply = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (pend && !sync && (pend_ch == 2'(i))) begin
        if (!en[i]) begin
          apply = 1'b1;
        end else if ((cnt[i] == half[i]) && (pend_en || clk_out[i])) begin
          apply = 1'b1;
        end
      end
    end
  end

  // Single config slot plus the done/err pulses.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      pend      <= 1'b0;
      pend_ch   <= 2'd0;
      pend_half <= 17'd0;
      pend_en   <= 1'b0;
      done_r    <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      done_r <= apply;
      err_r  <= accept && (cfg.cfg_ch == 2'd3);
      if (accept && (cfg.cfg_ch != 2'd3)) begin
        pend      <= 1'b1;
        pend_ch   <= cfg.cfg_ch;
        pend_half <= cfg.cfg_half;
        pend_en   <= cfg.cfg_en;
      end else if (apply) begin
        pend <= 1'b0;
      end
    end
  end

  // Per-channel divider: count to half, toggle, strobe tick; absorb config on apply.
  always_ff @(posedge clk_in) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        cnt[i]     <= 17'd0;
        clk_out[i] <= 1'b0;
        tick[i]    <= 1'b0;
        half[i]    <= half_def(i);
        en[i]      <= EN_DEF[i];
      end else if (sync) begin
        cnt[i]     <= 17'd0;
        clk_out[i] <= 1'b0;
        tick[i]    <= 1'b0;
      end else if (apply && (pend_ch == 2'(i)) && !en[i]) begin
        // Freshly (re)configured idle channel restarts from a clean phase.
        en[i]      <= pend_en;
        half[i]    <= pend_half;
        cnt[i]     <= 17'd0;
        clk_out[i] <= 1'b0;
        tick[i]    <= 1'b0;
      end else if (en[i]) begin
        if (cnt[i] == half[i]) begin
          cnt[i]     <= 17'd0;
          clk_out[i] <= ~clk_out[i];
          tick[i]    <= 1'b1;
          if (apply && (pend_ch == 2'(i))) begin
            half[i] <= pend_half;
            en[i]   <= pend_en;
          end
        end else begin
          cnt[i]  <= cnt[i] + 17'd1;
          tick[i] <= 1'b0;
        end
      end else begin
        cnt[i]     <= 17'd0;
        clk_out[i] <= 1'b0;
        tick[i]    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_clkdiv_sched.sv
// Bench for clkdiv_sched: schedule-based reference model feeding an expectation queue.
// Latency: expectations for each clock edge are checked 1 time unit after that edge.
// Backpressure: requests are held until cfg_ready is seen high.
module tb_clkdiv_sched;

  logic       clk_in = 1'b0;
  logic       rst    = 1'b1;
`ifdef CLKDIV_SCHED_SYNC_EN
  logic       sync_req = 1'b0;
`endif
  logic [2:0] clk_out;
  logic [2:0] tick;

  clkdiv_sched_if ifc ();

  clkdiv_sched dut (
    .clk_in  (clk_in),
    .rst     (rst),
`ifdef CLKDIV_SCHED_SYNC_EN
    .sync_req(sync_req),
`endif
    .cfg     (ifc),
    .clk_out (clk_out),
    .tick    (tick)
  );

  always #5 clk_in = ~clk_in;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int         eno;
    logic [2:0] clk;
    logic [2:0] tk;
    logic       rdy;
    logic       done;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  exp_t pe;
  exp_t me;

  // Reference model: each channel is a schedule of absolute toggle edges.
  int cyc = 0;
  int nxt [3];
  int hh  [3];
  bit men [3];
  bit lvl [3];
  bit mp;
  bit mp_pre;
  int p_ch;
  int p_half;
  bit p_en;
  int p_edge;

  function automatic int def_h(input int i);
    case (i)
      0:       return 53;
      1:       return 26;
      default: return 1060;
    endcase
  endfunction

  // Predictor: samples the inputs seen at each edge and queues the expected outputs.
  always @(posedge clk_in) begin
    cyc = cyc + 1;
    pe.eno  = cyc;
    pe.tk   = 3'b000;
    pe.done = 1'b0;
    pe.err  = 1'b0;
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        hh[i]  = def_h(i);
        men[i] = 1'b1;
        lvl[i] = 1'b0;
        nxt[i] = cyc + hh[i] + 1;
      end
      mp = 1'b0;
    end else begin
      mp_pre = mp;
      for (int i = 0; i < 3; i++) begin
        if (mp && p_ch == i && cyc == p_edge) begin
          if (!men[i]) begin
            lvl[i] = 1'b0;
          end else begin
            lvl[i]   = !lvl[i];
            pe.tk[i] = 1'b1;
          end
          men[i]  = p_en;
          hh[i]   = p_half;
          nxt[i]  = cyc + hh[i] + 1;
          pe.done = 1'b1;
          mp      = 1'b0;
        end else if (men[i] && cyc == nxt[i]) begin
          lvl[i]   = !lvl[i];
          pe.tk[i] = 1'b1;
          nxt[i]   = cyc + hh[i] + 1;
        end
      end
      if (ifc.cfg_valid && !mp_pre) begin
        if (ifc.cfg_ch == 2'd3) begin
          pe.err = 1'b1;
        end else begin
          mp     = 1'b1;
          p_ch   = int'(ifc.cfg_ch);
          p_half = int'(ifc.cfg_half);
          p_en   = ifc.cfg_en;
          if (!men[p_ch])
            p_edge = cyc + 1;
          else if (p_en || lvl[p_ch])
            p_edge = nxt[p_ch];
          else
            p_edge = nxt[p_ch] + hh[p_ch] + 1;
        end
      end
    end
    for (int i = 0; i < 3; i++) pe.clk[i] = lvl[i];
    pe.rdy = !mp;
    exp_q.push_back(pe);
  end

  task automatic chk(input string nm, input logic [2:0] act, input logic [2:0] exp, input int eno);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at edge %0d: got %b, expected %b", nm, eno, act, exp);
    end
  endtask

  // Monitor: pops one expectation per edge and compares the DUT outputs.
  always @(posedge clk_in) begin
    #1;
    if (exp_q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL exp_queue_empty at time %0t: got no entry, expected one", $time);
    end else begin
      me = exp_q.pop_front();
      chk("clk_out",   clk_out,       me.clk,  me.eno);
      chk("tick",      tick,          me.tk,   me.eno);
      chk("cfg_ready", ifc.cfg_ready, me.rdy,  me.eno);
      chk("cfg_done",  ifc.cfg_done,  me.done, me.eno);
      chk("cfg_err",   ifc.cfg_err,   me.err,  me.eno);
    end
  end

  // Drive one request from a negedge and hold it until the slot is free.
  task automatic send(input int ch, input int h, input int e);
    int w;
    w = 0;
    ifc.cfg_valid = 1'b1;
    ifc.cfg_ch    = 2'(ch);
    ifc.cfg_half  = 17'(h);
    ifc.cfg_en    = e[0];
    while (!ifc.cfg_ready && w < 5000) begin
      @(negedge clk_in);
      w++;
    end
    if (w >= 5000) begin
      tests++;
      fails++;
      $display("FAIL send_timeout ch %0d: cfg_ready stayed %b, expected 1", ch, ifc.cfg_ready);
    end
    @(negedge clk_in);
    ifc.cfg_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while (!ifc.cfg_ready && w < 5000) begin
      @(negedge clk_in);
      w++;
    end
  endtask

  task automatic wait_level(input int ch, input logic lv);
    int w;
    w = 0;
    while (clk_out[ch] !== lv && w < 300) begin
      @(negedge clk_in);
      w++;
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clk_in);
    rst = 1'b1;
    repeat (n) @(negedge clk_in);
    rst = 1'b0;
  endtask

  initial begin
    ifc.cfg_valid = 1'b0;
    ifc.cfg_ch    = 2'd0;
    ifc.cfg_half  = 17'd0;
    ifc.cfg_en    = 1'b0;
    repeat (3) @(negedge clk_in);
    rst = 1'b0;

    // Default divider rates after reset.
    repeat (300) @(negedge clk_in);

    // Shorten ch1 in the middle of a half-period.
    send(1, 9, 1);
    wait_idle();
    repeat (40) @(negedge clk_in);

    // Disable ch0 while it is low: must wait for the falling terminal.
    wait_level(0, 1'b0);
    send(0, 5, 0);
    wait_idle();
    repeat (20) @(negedge clk_in);

    // Park ch2, then re-enable at half=0 with a second request right behind.
    send(2, 1060, 0);
    wait_idle();
    send(2, 0, 1);
    send(1, 3, 1);
    wait_idle();
    repeat (20) @(negedge clk_in);

    // Invalid channel request.
    send(3, 7, 1);
    repeat (5) @(negedge clk_in);

    // Reset while a glitch-free disable is still waiting.
    send(1, 40, 1);
    wait_idle();
    wait_level(1, 1'b0);
    send(1, 5, 0);
    @(negedge clk_in);
    do_reset(2);
    repeat (60) @(negedge clk_in);

    // Randomised config traffic with occasional resets.
    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(0, 30)) @(negedge clk_in);
      if ($urandom_range(0, 9) == 0) do_reset($urandom_range(1, 3));
      send($urandom_range(0, 3), $urandom_range(0, 40), $urandom_range(0, 1));
    end
    wait_idle();
    repeat (100) @(negedge clk_in);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/clkdiv_sched.md
CLKDIV_SCHED -- requirements
Module: clkdiv_sched

Interface
REQ-001 SHALL have parameter HALF0_DEF, default 53: reset half-period terminal count, channel 0.
REQ-002 SHALL have parameter HALF1_DEF, default 26: reset half-period terminal count, channel 1.
REQ-003 SHALL have parameter HALF2_DEF, default 1060: reset half-period terminal count, channel 2.
REQ-004 SHALL have parameter EN_DEF, default 3'b111: reset enable mask, bit i = channel i.
REQ-005 SHALL have port clk_in  input  1  sole clock, all logic on its rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port cfg_valid  input  1  config request valid.
REQ-008 SHALL have port cfg_ready  output  1  config slot free.
REQ-009 SHALL have port cfg_ch  input  2  target channel; 3 = invalid.
REQ-010 SHALL have port cfg_half  input  17  new terminal count.
REQ-011 SHALL have port cfg_en  input  1  new enable.
REQ-012 SHALL have port cfg_done  output  1  one-cycle pulse when the pending config is applied.
REQ-013 SHALL have port cfg_err  output  1  one-cycle pulse when an invalid-channel request is dropped.
REQ-014 SHALL have port clk_out  output  3  divided clocks, bit i = channel i.
REQ-015 SHALL have port tick  output  3  one-cycle strobe on every clk_out[i] toggle.

Function
REQ-016 Channel enabled: cnt==half -> cnt<=0, clk_out toggles, tick=1 the next cycle; otherwise cnt<=cnt+1; period 2*(half+1) cycles; half=0 legal (toggle every cycle).
REQ-017 Channel disabled: cnt held 0, clk_out held 0, tick 0.
REQ-018 Counters 17 bits, compared by equality; no wrap-around occurs because half <= 2^17-1.
REQ-019 Handshake: accept when cfg_valid&&cfg_ready; cfg_ready = no pending; one pending slot (ch, half, en).
REQ-020 cfg_ch==3 accepted: not stored, cfg_err pulses the next cycle, cfg_ready stays 1.
REQ-021 Apply rules, evaluated from the cycle after acceptance (never the acceptance cycle itself):
- target disabled: apply in the first evaluated cycle.
- target enabled with cfg_en=1: apply at the target's next terminal (cnt==old half); new half governs the following half-period.
- target enabled with cfg_en=0: apply only at a terminal where clk_out==1, so the output falls and stays 0 (glitch-free).
REQ-022 Enabling a disabled channel: cnt starts at 0 and clk_out at 0 in the cycle after apply.
REQ-023 Apply cycle: registers updated, pending cleared, cfg_done=1 the next cycle, cfg_ready=1 the next cycle.
REQ-024 Non-target channels are never disturbed by config activity.

Reset
REQ-025 With rst high at a clock edge: cnt=0, clk_out=0, tick=0, half=HALFi_DEF, en=EN_DEF, pending cleared, cfg_ready=1, cfg_done=0, cfg_err=0.
REQ-026 A cfg handshake in a reset cycle is ignored; reset mid-wait discards the pending config without asserting cfg_done.

Configuration
REQ-027 Macro CLKDIV_SCHED_SYNC_EN defined: adds input sync_req (1 bit); when sync_req=1, all channels get cnt<=0 and clk_out<=0, and tick=0 in that cycle; a pending config is not applied in a sync cycle; sync overrides a simultaneous terminal; reset overrides sync.
REQ-028 CLKDIV_SCHED_SYNC_EN undefined: sync_req port absent; behaviour otherwise identical.

Verification
REQ-029 Release reset, run 300 cycles -> ch1 toggles every 27 cycles, ch0 every 54, ch2 every 1061; tick aligned with each toggle.
REQ-030 Config ch1 half=9 mid-half-period -> previous half-period completes at 27 cycles; subsequent toggles every 10; cfg_done 1 cycle after apply; cfg_ready low meanwhile.
REQ-031 Config ch0 en=0 while clk_out[0]=0 -> no apply at the next terminal (rising); apply at the following falling terminal; clk_out[0] stays 0 afterwards.
REQ-032 Config ch2 en=1 half=0 while disabled -> applied 1 cycle after acceptance; clk_out[2] toggles every cycle; second request held off (cfg_ready=0) until cfg_done.
REQ-033 cfg_ch=3 -> cfg_err pulse, no channel change, cfg_ready stays 1; rst asserted while pending -> defaults restored, no cfg_done.
REQ-034 With CLKDIV_SCHED_SYNC_EN defined: sync_req pulsed on a ch1 terminal cycle -> no tick, all outputs 0, toggles resume half+1 cycles later.
